// File: rtl/mux_scan.sv
// Sequencer that walks a 4:1 data selector through channels 0..3 and assembles the returned bits into a word.
// Build option: define MUX_SCAN_AUTO_EN to restart the scan directly after each DONE handshake.
module mux_scan #(
  parameter int SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [1:0] sel,
  input  logic       y_in,
  output logic [3:0] word,
  output logic       word_valid,
  input  logic       word_ready,
  output logic       busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // With no settle time a channel is sampled on the edge right after its select change.
  localparam state_t     FIRST_C       = (SETTLE > 0) ? ST_SETTLE : ST_SAMPLE;
  localparam logic [3:0] SETTLE_LAST_C = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;

  state_t     state_r;
  logic [1:0] sel_r;
  logic [3:0] cnt_r;
  logic [3:0] word_r;
  logic       valid_r;
  logic       busy_r;

  assign sel        = sel_r;
  assign word       = word_r;
  assign word_valid = valid_r;
  assign busy       = busy_r;

  // Scan state machine; every output comes straight from a register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      sel_r   <= 2'd0;
      cnt_r   <= 4'd0;
      word_r  <= 4'd0;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            sel_r   <= 2'd0;
            cnt_r   <= 4'd0;
            state_r <= FIRST_C;
            busy_r  <= 1'b1;
          end else begin
            sel_r  <= 2'd0;
            busy_r <= 1'b0;
          end
        end
        ST_SETTLE: begin
          if (cnt_r == SETTLE_LAST_C) begin
            state_r <= ST_SAMPLE;
          end else begin
            cnt_r <= cnt_r + 4'd1;
          end
        end
        ST_SAMPLE: begin
          word_r[sel_r] <= y_in;
          if (sel_r == 2'd3) begin
            sel_r   <= 2'd0;
            valid_r <= 1'b1;
            state_r <= ST_DONE;
          end else begin
            sel_r   <= sel_r + 2'd1;
            cnt_r   <= 4'd0;
            state_r <= FIRST_C;
          end
        end
        ST_DONE: begin
          if (valid_r && word_ready) begin
            valid_r <= 1'b0;
`ifdef MUX_SCAN_AUTO_EN
            sel_r   <= 2'd0;
            cnt_r   <= 4'd0;
            state_r <= FIRST_C;
`else
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
`endif
          end else begin
            sel_r <= 2'd0;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          sel_r   <= 2'd0;
          cnt_r   <= 4'd0;
          valid_r <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mux_scan.md
MUX_SCAN -- requirements
Module: mux_scan

Interface
REQ-001 Parameter SETTLE, default 1: number of settle cycles per channel after the select lines change, legal range 0..15.
REQ-002 clk  input  1  single rising-edge clock for all state.
REQ-003 rst  input  1  synchronous reset, active-high.
REQ-004 start  input  1  scan request, sampled only in IDLE.
REQ-005 sel  output  2  select lines {S1,S0} driven to the downstream 4:1 data selector.
REQ-006 y_in  input  1  selector output Y returned from the 4:1 data selector.
REQ-007 word  output  4  captured scan result; word[k] = y_in sampled while sel==k.
REQ-008 word_valid  output  1  word is complete and stable.
REQ-009 word_ready  input  1  consumer accepts word.
REQ-010 busy  output  1  high in any state other than IDLE.

Function
REQ-011 FSM states SHALL be IDLE, SETTLE, SAMPLE and DONE, all registered.
REQ-012 IDLE transition: start=1 at edge E0 -> sel=0, settle counter=0; next state SETTLE if SETTLE>0, else SAMPLE.
REQ-013 SETTLE: hold sel; increment counter each cycle; go to SAMPLE on the edge where counter reaches SETTLE-1.
REQ-014 SAMPLE: at the edge, set word[sel]=y_in.
REQ-015 SAMPLE with sel<3: increment sel, clear counter, go to SETTLE (or stay in SAMPLE if SETTLE=0).
REQ-016 SAMPLE with sel==3: go to DONE, set word_valid=1, set sel=0.
REQ-017 Channel k SHALL be sampled at edge E0+(k+1)*(SETTLE+1).
REQ-018 word_valid SHALL rise immediately after edge E0+4*(SETTLE+1); with SETTLE=1 that is edge E0+8.
REQ-019 DONE: hold word and word_valid stable until word_valid&&word_ready at an edge.
REQ-020 After that handshake, word_valid SHALL be 0 from that edge and the state SHALL return to IDLE; word retains its value.
REQ-021 start SHALL be ignored in SETTLE, SAMPLE and DONE; no queuing of requests.
REQ-022 word_ready SHALL be ignored while word_valid=0.
REQ-023 Bits of word not yet sampled in the current scan SHALL keep their previous values; only the completed word is meaningful when word_valid=1.
REQ-024 sel SHALL change only on clock edges and SHALL never skip a channel.
REQ-025 sel SHALL be 0 in IDLE and DONE.

Reset
REQ-026 rst=1 at an edge forces state=IDLE, sel=0, word=0, word_valid=0, busy=0 and settle counter=0, with priority over all other inputs.
REQ-027 Reset mid-scan or in DONE SHALL abort without emitting a word; the first scan after reset starts only on a new start in IDLE.

Configuration
REQ-028 The macro MUX_SCAN_AUTO_EN selects auto-rescan mode.
REQ-029 With MUX_SCAN_AUTO_EN defined, the DONE handshake goes directly to channel 0 (SETTLE or SAMPLE per REQ-012) without start, so busy stays 1.
REQ-030 With MUX_SCAN_AUTO_EN defined, the first scan after reset still requires start.
REQ-031 Without MUX_SCAN_AUTO_EN, behaviour is exactly REQ-020.

Verification
REQ-032 Bench drives y_in from a data_sel model wired as L with D0=A, D1=0, D2=A, D3=1 and sel={B,C}.
REQ-033 A=1, SETTLE=1, start pulse at E0 -> word=4'b1101, word_valid rises after E0+8.
REQ-034 A=0, SETTLE=0, start at E0 -> word=4'b1000, word_valid after E0+4.
REQ-035 word_ready held 0 for 10 cycles in DONE with start pulsed -> word and word_valid stable, no rescan; word_ready=1 -> word_valid=0 next cycle, busy=0.
REQ-036 rst asserted while sel==2 mid-scan -> next cycle: sel=0, word=0, word_valid=0, busy=0; no word emitted.
REQ-037 MUX_SCAN_AUTO_EN defined, word_ready tied 1, A toggled between scans -> words alternate 4'b1101 / 4'b1000 back-to-back with no start after the first.
